// File: rtl/alu32_scheduler.sv
// alu32_scheduler: round-robin two-port sequencer sharing one alu32 over valid/ready handshakes.
// Define ALU_SCHED_FIXED_PRIO_EN for fixed priority (port 0 always wins, no rr_ptr).
module alu32_scheduler #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid0,
  input  logic             req_valid1,
  output logic             req_ready0,
  output logic             req_ready1,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  input  logic             rsp_ready0,
  input  logic             rsp_ready1,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_cout,
  output logic [3:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  input  logic             alu_cout
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic gnt, win, any;
`ifdef ALU_SCHED_FIXED_PRIO_EN
  assign win = ~req_valid0;
`else
  logic rr_ptr;
  // Preferred port wins when valid, otherwise the other one does.
  assign win = (rr_ptr ? req_valid1 : req_valid0) ? rr_ptr : ~rr_ptr;
`endif
  assign any = req_valid0 | req_valid1;
  assign req_ready0 = (state == IDLE) && any && !win;
  assign req_ready1 = (state == IDLE) && any && win;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 1'b0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
      rr_ptr     <= 1'b0;
`endif
      alu_sel    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_cout   <= 1'b0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          alu_sel <= {1'b0, win ? req_op1 : req_op0};
          alu_a   <= win ? req_a1 : req_a0;
          alu_b   <= win ? req_b1 : req_b0;
          gnt     <= win;
          state   <= EXEC;
        end
        EXEC: begin
          rsp_result <= alu_r;
          rsp_zero   <= alu_zero;
          rsp_ovf    <= alu_ovf;
          rsp_cout   <= alu_cout;
          rsp_valid0 <= ~gnt;
          rsp_valid1 <= gnt;
          state      <= RESP;
        end
        RESP: if (gnt ? rsp_ready1 : rsp_ready0) begin
          rsp_valid0 <= 1'b0;
          rsp_valid1 <= 1'b0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
          rr_ptr     <= ~gnt;
`endif
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu32_scheduler.sv
// tb_alu32_scheduler: directed bench with a stub XOR ALU; inputs driven and outputs sampled at negedge.
module tb_alu32_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid0 = 0, req_valid1 = 0, rsp_ready0 = 0, rsp_ready1 = 0;
  logic [2:0] req_op0 = 0, req_op1 = 0;
  logic [31:0] req_a0 = 0, req_b0 = 0, req_a1 = 0, req_b1 = 0;
  logic req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_zero, rsp_ovf, rsp_cout;
  logic [31:0] rsp_result, alu_a, alu_b, alu_r;
  logic [3:0] alu_sel;
  logic alu_zero, alu_ovf, alu_cout;
  int checks = 0, failures = 0;
  int n_acc;
  int acc_cyc[4];
  logic acc_port[4];
  logic exp_g[4];

  always #5 clk = ~clk;

  assign alu_r    = alu_a ^ alu_b;
  assign alu_zero = (alu_r == 32'h0);
  assign alu_ovf  = alu_a[31];
  assign alu_cout = alu_b[0];

  alu32_scheduler #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_cout(rsp_cout),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_cout(alu_cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_hs", {28'h0, req_ready0, req_ready1, rsp_valid0, rsp_valid1}, 32'h0);
    chk("rst_flags", {29'h0, rsp_zero, rsp_ovf, rsp_cout}, 32'h0);
    chk("rst_sel", {28'h0, alu_sel}, 32'h0);
    chk("rst_a", alu_a, 32'h0);
    chk("rst_b", alu_b, 32'h0);
    chk("rst_res", rsp_result, 32'h0);

    // single request on port 0
    req_valid0 = 1; req_op0 = 3'b010; req_a0 = 32'hFC00_4089; req_b0 = 32'h0000_000F;
    #1;
    chk("p0_ready", {30'h0, req_ready0, req_ready1}, 32'h2);
    tick();
    req_valid0 = 0;
    chk("p0_ready_drop", {31'h0, req_ready0}, 32'h0);
    chk("p0_sel", {28'h0, alu_sel}, 32'h2);
    chk("p0_alu_a", alu_a, 32'hFC00_4089);
    chk("p0_exec_rv", {31'h0, rsp_valid0}, 32'h0);
    tick();
    chk("p0_rv", {30'h0, rsp_valid0, rsp_valid1}, 32'h2);
    chk("p0_res", rsp_result, 32'hFC00_4086);
    chk("p0_flags", {29'h0, rsp_zero, rsp_ovf, rsp_cout}, 32'h3);
    rsp_ready0 = 1;
    tick();
    rsp_ready0 = 0;
    chk("p0_rv_drop", {30'h0, rsp_valid0, rsp_valid1}, 32'h0);

    // zero flag on port 1; rsp_ready0 must be ignored while port 1 holds the response
    req_valid1 = 1; req_op1 = 3'b000; req_a1 = 32'h043F_FFFF; req_b1 = 32'h043F_FFFF;
    #1;
    chk("p1_ready", {30'h0, req_ready0, req_ready1}, 32'h1);
    tick();
    req_valid1 = 0;
    tick();
    chk("p1_rv", {30'h0, rsp_valid0, rsp_valid1}, 32'h1);
    chk("p1_res", rsp_result, 32'h0);
    chk("p1_flags", {29'h0, rsp_zero, rsp_ovf, rsp_cout}, 32'h5);
    rsp_ready0 = 1;
    tick();
    chk("p1_ignore_rdy0", {30'h0, rsp_valid0, rsp_valid1}, 32'h1);
    rsp_ready0 = 0; rsp_ready1 = 1;
    tick();
    chk("p1_rv_drop", {30'h0, rsp_valid0, rsp_valid1}, 32'h0);

    // contention with both responders always ready
    rsp_ready0 = 1; rsp_ready1 = 1;
    req_valid0 = 1; req_op0 = 3'b001; req_a0 = 32'h11; req_b0 = 32'h0;
    req_valid1 = 1; req_op1 = 3'b011; req_a1 = 32'h22; req_b1 = 32'h0;
    n_acc = 0;
    #1;
    for (int c = 0; c < 12; c++) begin
      if ((req_ready0 || req_ready1) && n_acc < 4) begin
        acc_cyc[n_acc] = c;
        acc_port[n_acc] = req_ready1;
        n_acc++;
      end
      if (rsp_valid0) chk("ct_res0", rsp_result, 32'h11);
      if (rsp_valid1) chk("ct_res1", rsp_result, 32'h22);
      tick();
      #1;
    end
    req_valid0 = 0; req_valid1 = 0;
    chk("ct_count", n_acc, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < n_acc) begin
        chk($sformatf("ct_port%0d", k), {31'h0, acc_port[k]}, {31'h0, exp_g[k]});
        chk($sformatf("ct_cyc%0d", k), acc_cyc[k], 3 * k);
      end
    end
    tick();

    // response backpressure on port 0 while port 1 waits
    rsp_ready0 = 0; rsp_ready1 = 0;
    req_valid0 = 1; req_op0 = 3'b001; req_a0 = 32'h5; req_b0 = 32'h3;
    tick();
    req_valid0 = 0;
    req_valid1 = 1; req_op1 = 3'b100; req_a1 = 32'h8000_0000; req_b1 = 32'h1;
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_rv", {30'h0, rsp_valid0, rsp_valid1}, 32'h2);
      chk("bp_res", rsp_result, 32'h6);
      chk("bp_flags", {29'h0, rsp_zero, rsp_ovf, rsp_cout}, 32'h1);
      chk("bp_rdy1", {31'h0, req_ready1}, 32'h0);
    end
    rsp_ready0 = 1;
    #1;
    chk("bp_rdy1_resp", {31'h0, req_ready1}, 32'h0);
    tick();
    rsp_ready0 = 0;
    chk("bp_rdy1_next", {30'h0, req_ready0, req_ready1}, 32'h1);
    chk("bp_rv_drop", {31'h0, rsp_valid0}, 32'h0);
    tick();
    req_valid1 = 0;
    tick();
    chk("bp_p1_rv", {30'h0, rsp_valid0, rsp_valid1}, 32'h1);
    chk("bp_p1_res", rsp_result, 32'h8000_0001);
    rsp_ready1 = 1;
    tick();
    rsp_ready1 = 0;

    // port 1 alone wins with rr_ptr back at 0; then reset during EXEC
    req_valid1 = 1; req_op1 = 3'b111; req_a1 = 32'hA5A5_0000; req_b1 = 32'h0000_5A5A;
    #1;
    chk("solo_p1", {30'h0, req_ready0, req_ready1}, 32'h1);
    tick();
    req_valid1 = 0;
    chk("rst_exec_sel", {28'h0, alu_sel}, 32'h7);
    rst = 1;
    #1;
    chk("async_a", alu_a, 32'h0);
    chk("async_sel", {28'h0, alu_sel}, 32'h0);
    tick(); tick();
    rst = 0;
    rsp_ready0 = 1; rsp_ready1 = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("stale_rv", {30'h0, rsp_valid0, rsp_valid1}, 32'h0);
    end
    chk("stale_res", rsp_result, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
